// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back, write-allocate L1 data cache controller
module dcache_ctrl #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_WORDS = 4,
   parameter int LINE_W     = 32 * LINE_WORDS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_write_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int WRD_W = $clog2(LINE_WORDS);
   localparam int OFF_W = WRD_W + 2;
   localparam int TAG_W = 32 - IDX_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
   state_t state_q, state_d;

   logic [LINE_W-1:0]    data_q [NUM_LINES];
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;

   // Miss line is captured so memory outputs stay stable even if the core drops its request.
   logic [TAG_W-1:0]     miss_tag_q;
   logic [IDX_W-1:0]     miss_idx_q;

   logic [TAG_W-1:0]     cpu_tag;
   logic [IDX_W-1:0]     cpu_idx;
   logic [WRD_W-1:0]     cpu_word;
   logic                 hit;
   logic                 store_hit;
   logic                 alloc_done;
   logic [31:0]          sel_word;
   logic                 unused_addr_bits;

   assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
   assign cpu_idx          = cpu_addr_i[OFF_W +: IDX_W];
   assign cpu_word         = cpu_addr_i[2 +: WRD_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign hit        = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign sel_word   = data_q[cpu_idx][{cpu_word, 5'd0} +: 32];
   assign store_hit  = (state_q == IDLE) && cpu_req_i && cpu_write_i && hit;
   assign alloc_done = (state_q == ALLOCATE) && mem_ack_i;

   assign cpu_stall_o = cpu_req_i && ((state_q != IDLE) || !hit);
   assign cpu_rdata_o = ((state_q == IDLE) && cpu_req_i && !cpu_write_i && hit) ? sel_word : 32'd0;

   always_comb begin
      state_d      = state_q;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'd0;
      mem_wdata_o  = '0;
      case (state_q)
         IDLE: begin
            if (cpu_req_i && !hit)
               state_d = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WRITEBACK : ALLOCATE;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
            mem_wdata_o  = data_q[miss_idx_q];
            if (mem_ack_i)
               state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
            if (mem_ack_i)
               state_d = REFILL;
         end
         REFILL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         dirty_q    <= '0;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && cpu_req_i && !hit) begin
            miss_tag_q <= cpu_tag;
            miss_idx_q <= cpu_idx;
         end
         if (alloc_done) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
         end
         if (store_hit)
            dirty_q[cpu_idx] <= 1'b1;
      end
   end

   // Data and tag storage carry no reset; valid bits alone define cache contents.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (alloc_done) begin
            data_q[miss_idx_q] <= mem_rdata_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
         end
         if (store_hit)
            data_q[cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_wdata_i;
      end
   end
endmodule
